dmem_dual: RTL and testbench

- Data-memory responder for the dual-issue pipeline; it is the memory end of both MEM-stage issue slots (slot 1 and slot 2).
- Serves combinational loads and clocked stores on each slot.
- Resolves same-cycle conflicts between slots in program order; slot 1 is older than slot 2.
- Provides two memory-mapped registers: a free-running cycle counter and a done/result register. The testbench uses these to end a program.

---
 rtl/dmem_dual_pkg.sv | 15 +
 rtl/dmem_addr_decode.sv | 28 ++
 rtl/dmem_dual.sv | 100 ++++++++++
 tb/tb_dmem_dual.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/dmem_dual_pkg.sv
// Shared constants and access-kind encoding for the dual-slot data memory.
package dmem_dual_pkg;

    localparam logic [31:0] CYC_ADDR       = 32'hFFFF_FFFC;
    localparam logic [31:0] DONE_ADDR      = 32'hFFFF_FFF8;
    localparam int unsigned DMEM_ADDR_BITS = 6;

    typedef enum logic [1:0] {
        KIND_RAM,
        KIND_CYC,
        KIND_DONE,
        KIND_UNMAPPED
    } access_kind_t;

endpackage

// File: rtl/dmem_addr_decode.sv
// Classifies one slot's byte address into RAM / cycle counter / done register / unmapped.
module dmem_addr_decode
    import dmem_dual_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DMEM_ADDR_BITS
) (
    input  logic [31:0]          addr,
    output access_kind_t         kind,
    output logic [ADDR_BITS-1:0] index,
    output logic                 misaligned
);

    always_comb begin
        kind = KIND_UNMAPPED;
        if (addr == CYC_ADDR) begin
            kind = KIND_CYC;
        end else if (addr == DONE_ADDR) begin
            kind = KIND_DONE;
        end else if (addr[31:ADDR_BITS+2] == '0) begin
            kind = KIND_RAM;
        end
    end

    // Byte offset never participates in indexing; it only raises the misalign flag.
    assign index      = addr[ADDR_BITS+1:2];
    assign misaligned = (addr[1:0] != 2'b00);

endmodule

// File: rtl/dmem_dual.sv
// Dual-slot data memory: combinational loads, clocked stores, slot 1 older than slot 2,
// plus a free-running cycle counter and a sticky done/result register.
module dmem_dual
    import dmem_dual_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DMEM_ADDR_BITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    input  logic        we2,
    input  logic [31:0] a2,
    input  logic [31:0] wd2,
    output logic [31:0] rd2,
    output logic        done,
    output logic [31:0] result,
    output logic        misalign
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [31:0]          mem [DEPTH];
    logic [31:0]          cycle;

    access_kind_t         kind1, kind2;
    logic [ADDR_BITS-1:0] idx1, idx2;
    logic                 mis1, mis2;

    dmem_addr_decode #(.ADDR_BITS(ADDR_BITS)) u_dec1 (
        .addr       (a),
        .kind       (kind1),
        .index      (idx1),
        .misaligned (mis1)
    );

    dmem_addr_decode #(.ADDR_BITS(ADDR_BITS)) u_dec2 (
        .addr       (a2),
        .kind       (kind2),
        .index      (idx2),
        .misaligned (mis2)
    );

    always_comb begin
        unique case (kind1)
            KIND_RAM:  rd = mem[idx1];
            KIND_CYC:  rd = cycle;
            KIND_DONE: rd = result;
            default:   rd = '0;
        endcase
    end

    // Slot 2 is younger, so it must observe a same-cycle slot-1 store.
    always_comb begin
        unique case (kind2)
            KIND_RAM:  rd2 = mem[idx2];
            KIND_CYC:  rd2 = cycle;
            KIND_DONE: rd2 = result;
            default:   rd2 = '0;
        endcase
        if (we && kind1 == KIND_RAM && kind2 == KIND_RAM && idx1 == idx2) begin
            rd2 = wd;
        end else if (we && kind1 == KIND_DONE && kind2 == KIND_DONE) begin
            rd2 = wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem      <= '{default: '0};
            cycle    <= '0;
            done     <= 1'b0;
            result   <= '0;
            misalign <= 1'b0;
        end else begin
            cycle <= cycle + 32'd1;
            // Slot-2 assignments come last so they win on a shared target.
            if (we && kind1 == KIND_RAM) begin
                mem[idx1] <= wd;
            end
            if (we2 && kind2 == KIND_RAM) begin
                mem[idx2] <= wd2;
            end
            if (we && kind1 == KIND_DONE) begin
                done   <= 1'b1;
                result <= wd;
            end
            if (we2 && kind2 == KIND_DONE) begin
                done   <= 1'b1;
                result <= wd2;
            end
            if ((we && mis1) || (we2 && mis2)) begin
                misalign <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_dual.sv
// Directed self-checking bench for dmem_dual with hand-computed expected values.
module tb_dmem_dual;

    localparam logic [31:0] CYC  = 32'hFFFF_FFFC;
    localparam logic [31:0] DONE = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset;
    logic        we, we2;
    logic [31:0] a, wd, a2, wd2;
    logic [31:0] rd, rd2, result;
    logic        done, misalign;

    int checks   = 0;
    int failures = 0;

    dmem_dual #(.ADDR_BITS(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .a        (a),
        .wd       (wd),
        .rd       (rd),
        .we2      (we2),
        .a2       (a2),
        .wd2      (wd2),
        .rd2      (rd2),
        .done     (done),
        .result   (result),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns after that.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; we2 = 1'b0;
        a = '0; wd = '0; a2 = '0; wd2 = '0;
        step();
        step();
        reset = 1'b0;

        // 1: reset state
        a = 32'h0; a2 = 32'h4; #1;
        check("rst_rd", rd, 32'h0);
        check("rst_rd2", rd2, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_misalign", {31'b0, misalign}, 32'h0);

        // 2: slot-1 store bypassed to slot-2 load
        we = 1'b1; a = 32'h8; wd = 32'hDEAD_BEEF; a2 = 32'h8; #1;
        check("bypass_rd2", rd2, 32'hDEAD_BEEF);
        check("bypass_rd_old", rd, 32'h0);
        step();
        we = 1'b0; #1;
        check("store_readback", rd, 32'hDEAD_BEEF);

        // 3: write priority and no reverse bypass
        we = 1'b1; a = 32'h10; wd = 32'h1; we2 = 1'b1; a2 = 32'h10; wd2 = 32'h2;
        step();
        we = 1'b0; we2 = 1'b0; #1;
        check("slot2_wins", rd, 32'h2);
        we2 = 1'b1; a2 = 32'h14; wd2 = 32'h5; a = 32'h14; #1;
        check("no_rev_bypass", rd, 32'h0);
        step();
        we2 = 1'b0; #1;
        check("slot2_store", rd, 32'h5);

        // top RAM word
        we = 1'b1; a = 32'hFC; wd = 32'h0BAD_F00D;
        step();
        we = 1'b0; a2 = 32'hFC; #1;
        check("top_word", rd2, 32'h0BAD_F00D);

        // 5: done/result register
        we2 = 1'b1; a2 = DONE; wd2 = 32'h2A; #1;
        check("done_before_edge", {31'b0, done}, 32'h0);
        step();
        we2 = 1'b0; #1;
        check("done_set", {31'b0, done}, 32'h1);
        check("result_2a", result, 32'h2A);
        a = DONE; #1;
        check("load_done_addr", rd, 32'h2A);
        we = 1'b1; wd = 32'h7; #1;
        check("done_bypass_rd2", rd2, 32'h7);
        step();
        we = 1'b0; #1;
        check("result_7", result, 32'h7);
        check("done_sticky", {31'b0, done}, 32'h1);
        we = 1'b1; wd = 32'h8; we2 = 1'b1; wd2 = 32'h9;
        step();
        we = 1'b0; we2 = 1'b0; #1;
        check("done_slot2_wins", result, 32'h9);

        // reset mid-run with a store pending
        we = 1'b1; a = 32'h20; wd = 32'h55; reset = 1'b1; #1;
        check("async_done", {31'b0, done}, 32'h0);
        check("async_result", result, 32'h0);
        step();
        reset = 1'b0; we = 1'b0; a = 32'h8; #1;
        check("rst_clears_ram", rd, 32'h0);
        a = 32'h20; #1;
        check("rst_drops_store", rd, 32'h0);

        // 4: cycle counter, ten edges after reset release
        for (int i = 0; i < 10; i++) step();
        we = 1'b1; a = CYC; wd = 32'h1234; #1;
        check("cyc_10", rd, 32'd10);
        step();
        we = 1'b0; a2 = CYC; #1;
        check("cyc_11", rd, 32'd11);
        check("cyc_11_rd2", rd2, 32'd11);

        // 6: misaligned and unmapped stores
        we = 1'b1; a = 32'h6; wd = 32'hCAFE_0001; #1;
        check("misalign_pre", {31'b0, misalign}, 32'h0);
        step();
        we = 1'b0; a = 32'h4; #1;
        check("misalign_set", {31'b0, misalign}, 32'h1);
        check("misalign_aligned", rd, 32'hCAFE_0001);
        we = 1'b1; a = 32'h0001_0000; wd = 32'hFFFF_FFFF;
        step();
        we = 1'b0; #1;
        check("unmapped_load", rd, 32'h0);
        a = 32'h0; #1;
        check("unmapped_no_ram", rd, 32'h0);
        check("misalign_sticky", {31'b0, misalign}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
